// File: rtl/branch_resolve_unit_if.sv
// Handshake, decoded control and result bundle of the branch resolve unit.
// The unit uses the slave modport; the driver of the unit uses the master modport.
interface branch_resolve_unit_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             i_flush;
   logic             i_valid;
   logic             o_ready;
   logic             i_is_branch;
   logic             i_is_jal;
   logic             i_is_jalr;
   logic [2:0]       i_funct3;
   logic             i_pred_taken;
   logic [XLEN-1:0]  i_pred_target;
   logic [XLEN-1:0]  i_pc;
   logic [XLEN-1:0]  i_op_1;
   logic [XLEN-1:0]  i_op_2;
   logic [XLEN-1:0]  i_imm;
   logic             o_valid;
   logic             i_ready;
   logic             o_taken;
   logic [XLEN-1:0]  o_target;
   logic [XLEN-1:0]  o_link;
   logic             o_redirect;
   logic             o_illegal;
   logic             o_misaligned;
   logic [CNT_W-1:0] o_cnt_branch;
   logic [CNT_W-1:0] o_cnt_taken;
   logic [CNT_W-1:0] o_cnt_mispred;

   modport slave (
      input  i_flush, i_valid, i_is_branch, i_is_jal, i_is_jalr, i_funct3,
             i_pred_taken, i_pred_target, i_pc, i_op_1, i_op_2, i_imm, i_ready,
      output o_ready, o_valid, o_taken, o_target, o_link, o_redirect,
             o_illegal, o_misaligned, o_cnt_branch, o_cnt_taken, o_cnt_mispred
   );

   modport master (
      output i_flush, i_valid, i_is_branch, i_is_jal, i_is_jalr, i_funct3,
             i_pred_taken, i_pred_target, i_pc, i_op_1, i_op_2, i_imm, i_ready,
      input  o_ready, o_valid, o_taken, o_target, o_link, o_redirect,
             o_illegal, o_misaligned, o_cnt_branch, o_cnt_taken, o_cnt_mispred
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// Two-stage RV32I branch/jump resolution: S1 compares and adds, S2 registers the
// result, detects mispredictions and keeps wrap-around retirement counters.
module branch_resolve_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   branch_resolve_unit_if.slave bus
);

   typedef struct packed {
      logic                   is_branch;
      logic                   is_jal;
      logic                   is_jalr;
      logic [2:0]             funct3;
      logic                   pred_taken;
      logic [XLEN-1:0]        pred_target;
      logic [XLEN-1:0]        pc;
      logic signed [XLEN-1:0] op_1;
      logic signed [XLEN-1:0] op_2;
      logic signed [XLEN-1:0] imm;
   } op_t;

   typedef struct packed {
      logic            taken;
      logic [XLEN-1:0] target;
      logic [XLEN-1:0] link;
      logic            redirect;
      logic            illegal;
      logic            misaligned;
      logic            cnt_br;
   } res_t;

   // Signed and unsigned less-than share one subtractor: op_1 + ~op_2 + 1.
   function automatic logic cond_met(input logic signed [XLEN-1:0] a,
                                     input logic signed [XLEN-1:0] b,
                                     input logic [2:0]             f3);
      logic [XLEN:0] d;
      logic          eq;
      logic          ltu;
      logic          lt;
      logic          ovf;
      d   = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
      eq  = (a == b);
      ltu = !d[XLEN];
      ovf = (a[XLEN-1] != b[XLEN-1]) && (d[XLEN-1] != a[XLEN-1]);
      lt  = d[XLEN-1] ^ ovf;
      case (f3)
         3'b000:  return eq;
         3'b001:  return !eq;
         3'b100:  return lt;
         3'b101:  return !lt;
         3'b110:  return ltu;
         3'b111:  return !ltu;
         default: return 1'b0;
      endcase
   endfunction

   function automatic res_t resolve(input op_t p);
      res_t            r;
      logic            jump;
      logic            any;
      logic            illegal;
      logic [XLEN-1:0] tgt;
      jump    = p.is_jal || p.is_jalr;
      any     = jump || p.is_branch;
      illegal = p.is_branch && (p.funct3[2:1] == 2'b01);
      tgt     = p.is_jalr ? ((p.op_1 + p.imm) & ~{{(XLEN-1){1'b0}}, 1'b1})
                          : (p.pc + p.imm);
      r.taken      = jump || (p.is_branch && !illegal && cond_met(p.op_1, p.op_2, p.funct3));
      r.link       = p.pc + XLEN'(4);
      r.target     = r.taken ? tgt : r.link;
      r.illegal    = illegal;
      r.misaligned = r.taken && tgt[1];
      // Faulting entries go to the trap path instead of redirecting fetch.
      r.redirect   = any && !illegal && !r.misaligned &&
                     ((r.taken != p.pred_taken) || (r.taken && (tgt != p.pred_target)));
      r.cnt_br     = p.is_branch && !illegal;
      return r;
   endfunction

   logic             vld_p1_q, vld_p1_d;
   logic             vld_p2_q, vld_p2_d;
   op_t              pay_p1_q, pay_p1_d;
   res_t             res_p2_q, res_p2_d;
   res_t             res_p1;
   logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
   logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;
   logic [CNT_W-1:0] cnt_mispred_q, cnt_mispred_d;
   logic             s2_load;
   logic             s1_ready;
   logic             consume;

   // ---- Stage 0 -> S1: accept from upstream ----
   always_comb begin
      s2_load  = !vld_p2_q || bus.i_ready;
      s1_ready = !vld_p1_q || s2_load;
      consume  = vld_p2_q && bus.i_ready;

      vld_p1_d = vld_p1_q;
      pay_p1_d = pay_p1_q;
      if (s1_ready) begin
         vld_p1_d = bus.i_valid;
         if (bus.i_valid) begin
            pay_p1_d = '{is_branch:   bus.i_is_branch,
                         is_jal:      bus.i_is_jal,
                         is_jalr:     bus.i_is_jalr,
                         funct3:      bus.i_funct3,
                         pred_taken:  bus.i_pred_taken,
                         pred_target: bus.i_pred_target,
                         pc:          bus.i_pc,
                         op_1:        bus.i_op_1,
                         op_2:        bus.i_op_2,
                         imm:         bus.i_imm};
         end
      end
      if (bus.i_flush) vld_p1_d = 1'b0;
   end

   // ---- S1 -> S2: resolve and register result ----
   always_comb begin
      res_p1   = resolve(pay_p1_q);
      vld_p2_d = vld_p2_q;
      res_p2_d = res_p2_q;
      if (s2_load) begin
         vld_p2_d = vld_p1_q;
         if (vld_p1_q) res_p2_d = res_p1;
      end
      if (bus.i_flush) vld_p2_d = 1'b0;
   end

   // ---- S2 -> retire: counters advance on consumption, flush or not ----
   always_comb begin
      cnt_branch_d  = cnt_branch_q;
      cnt_taken_d   = cnt_taken_q;
      cnt_mispred_d = cnt_mispred_q;
      if (consume) begin
         cnt_branch_d  = cnt_branch_q  + {{(CNT_W-1){1'b0}}, res_p2_q.cnt_br};
         cnt_taken_d   = cnt_taken_q   + {{(CNT_W-1){1'b0}}, res_p2_q.taken};
         cnt_mispred_d = cnt_mispred_q + {{(CNT_W-1){1'b0}}, res_p2_q.redirect};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q      <= 1'b0;
         vld_p2_q      <= 1'b0;
         res_p2_q      <= '0;
         cnt_branch_q  <= '0;
         cnt_taken_q   <= '0;
         cnt_mispred_q <= '0;
      end else begin
         vld_p1_q      <= vld_p1_d;
         vld_p2_q      <= vld_p2_d;
         res_p2_q      <= res_p2_d;
         cnt_branch_q  <= cnt_branch_d;
         cnt_taken_q   <= cnt_taken_d;
         cnt_mispred_q <= cnt_mispred_d;
      end
   end

   always_ff @(posedge clk) begin
      pay_p1_q <= pay_p1_d;
   end

   assign bus.o_ready       = s1_ready;
   assign bus.o_valid       = vld_p2_q;
   assign bus.o_taken       = res_p2_q.taken;
   assign bus.o_target      = res_p2_q.target;
   assign bus.o_link        = res_p2_q.link;
   assign bus.o_redirect    = res_p2_q.redirect;
   assign bus.o_illegal     = res_p2_q.illegal;
   assign bus.o_misaligned  = res_p2_q.misaligned;
   assign bus.o_cnt_branch  = cnt_branch_q;
   assign bus.o_cnt_taken   = cnt_taken_q;
   assign bus.o_cnt_mispred = cnt_mispred_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, hand-written pipeline
// sequences and randomized traffic against a queue-based reference model.
module tb_branch_resolve_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_resolve_unit_if #(.XLEN(32), .CNT_W(32)) bus ();
   branch_resolve_unit_if #(.XLEN(32), .CNT_W(3))  bus_s ();

   branch_resolve_unit #(.XLEN(32), .CNT_W(32)) dut   (.clk(clk), .rst(rst), .bus(bus));
   branch_resolve_unit #(.XLEN(32), .CNT_W(3))  dut_s (.clk(clk), .rst(rst), .bus(bus_s));

   typedef struct packed {
      logic        br, jal, jalr;
      logic [2:0]  f3;
      logic        pred;
      logic [31:0] pt, pc, op1, op2, imm;
   } in_t;

   typedef struct packed {
      logic        taken;
      logic [31:0] target, link;
      logic        redirect, illegal, mis;
   } res_t;

   typedef struct { in_t x; res_t e; } vec_t;
   typedef struct { int stage; res_t r; logic cbr; } ent_t;

   ent_t        mq[$];
   logic [31:0] m_cbr, m_ctk, m_cmp;
   int          total = 0;
   int          bad   = 0;
   logic        last_rdy;
   in_t         idle  = '0;

   task automatic chk1(input string n, input logic a, input logic e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0b want %0b", n, a, e);
      end
   endtask

   task automatic chk32(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask

   // Reference: RV32I branch semantics written directly from the ISA rules.
   function automatic res_t ref_res(input in_t x);
      res_t        r;
      logic        c;
      logic [31:0] tgt;
      case (x.f3)
         3'd0:    c = (x.op1 == x.op2);
         3'd1:    c = (x.op1 != x.op2);
         3'd4:    c = ($signed(x.op1) <  $signed(x.op2));
         3'd5:    c = ($signed(x.op1) >= $signed(x.op2));
         3'd6:    c = (x.op1 <  x.op2);
         3'd7:    c = (x.op1 >= x.op2);
         default: c = 1'b0;
      endcase
      r.illegal  = x.br && (x.f3 == 3'd2 || x.f3 == 3'd3);
      r.taken    = x.jal || x.jalr || (x.br && c);
      tgt        = x.jalr ? ((x.op1 + x.imm) & 32'hFFFF_FFFE) : (x.pc + x.imm);
      r.link     = x.pc + 32'd4;
      r.target   = r.taken ? tgt : r.link;
      r.mis      = r.taken && tgt[1];
      r.redirect = (x.br || x.jal || x.jalr) && !r.illegal && !r.mis &&
                   ((r.taken != x.pred) || (r.taken && tgt != x.pt));
      return r;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   function automatic in_t rand_in();
      in_t         x;
      int          k;
      logic [31:0] r;
      logic [31:0] tgt;
      k      = $urandom_range(0, 9);
      x.br   = (k < 6);
      x.jal  = (k == 6 || k == 7);
      x.jalr = (k == 8);
      x.f3   = 3'($urandom_range(0, 7));
      x.op1  = pick();
      x.op2  = ($urandom_range(0, 3) == 0) ? x.op1 : pick();
      x.pc   = $urandom & 32'hFFFF_FFFC;
      r      = $urandom;
      x.imm  = {{20{r[11]}}, r[11:0]} & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
      x.pred = 1'($urandom_range(0, 1));
      tgt    = x.jalr ? ((x.op1 + x.imm) & 32'hFFFF_FFFE) : (x.pc + x.imm);
      x.pt   = ($urandom_range(0, 1) == 0) ? tgt : $urandom;
      return x;
   endfunction

   function automatic in_t mk(input logic br, input logic jal, input logic jalr,
                              input logic [2:0] f3, input logic pred, input logic [31:0] pt,
                              input logic [31:0] pc, input logic [31:0] op1,
                              input logic [31:0] op2, input logic [31:0] imm);
      in_t x;
      x.br = br; x.jal = jal; x.jalr = jalr; x.f3 = f3; x.pred = pred; x.pt = pt;
      x.pc = pc; x.op1 = op1; x.op2 = op2; x.imm = imm;
      return x;
   endfunction

   function automatic res_t mr(input logic taken, input logic [31:0] target,
                               input logic [31:0] link, input logic redirect,
                               input logic illegal, input logic mis);
      res_t r;
      r.taken = taken; r.target = target; r.link = link;
      r.redirect = redirect; r.illegal = illegal; r.mis = mis;
      return r;
   endfunction

   task automatic drive(input in_t x, input logic v, input logic rdy, input logic fl);
      bus.i_valid       = v;
      bus.i_ready       = rdy;
      bus.i_flush       = fl;
      bus.i_is_branch   = x.br;
      bus.i_is_jal      = x.jal;
      bus.i_is_jalr     = x.jalr;
      bus.i_funct3      = x.f3;
      bus.i_pred_taken  = x.pred;
      bus.i_pred_target = x.pt;
      bus.i_pc          = x.pc;
      bus.i_op_1        = x.op1;
      bus.i_op_2        = x.op2;
      bus.i_imm         = x.imm;
   endtask

   task automatic drive_s(input logic v, input logic [31:0] pc);
      bus_s.i_valid       = v;
      bus_s.i_ready       = 1'b1;
      bus_s.i_flush       = 1'b0;
      bus_s.i_is_branch   = 1'b0;
      bus_s.i_is_jal      = 1'b1;
      bus_s.i_is_jalr     = 1'b0;
      bus_s.i_funct3      = 3'd0;
      bus_s.i_pred_taken  = 1'b1;
      bus_s.i_pred_target = pc + 32'd8;
      bus_s.i_pc          = pc;
      bus_s.i_op_1        = 32'd0;
      bus_s.i_op_2        = 32'd0;
      bus_s.i_imm         = 32'd8;
   endtask

   task automatic check_outputs();
      logic mv;
      mv = (mq.size() > 0) && (mq[0].stage == 2);
      chk1("o_valid", bus.o_valid, mv);
      if (mv) begin
         chk1 ("o_taken",      bus.o_taken,      mq[0].r.taken);
         chk32("o_target",     bus.o_target,     mq[0].r.target);
         chk32("o_link",       bus.o_link,       mq[0].r.link);
         chk1 ("o_redirect",   bus.o_redirect,   mq[0].r.redirect);
         chk1 ("o_illegal",    bus.o_illegal,    mq[0].r.illegal);
         chk1 ("o_misaligned", bus.o_misaligned, mq[0].r.mis);
      end
      chk32("cnt_branch",  bus.o_cnt_branch,  m_cbr);
      chk32("cnt_taken",   bus.o_cnt_taken,   m_ctk);
      chk32("cnt_mispred", bus.o_cnt_mispred, m_cmp);
   endtask

   // One clock: model holds at most two entries; an entry ages one stage per cycle
   // unless the output slot ahead of it is still occupied.
   task automatic cycle(input in_t x, input logic v, input logic rdy, input logic fl);
      logic exp_rdy;
      logic ovm;
      ent_t e;
      drive(x, v, rdy, fl);
      #1;
      exp_rdy  = (mq.size() < 2) || rdy;
      last_rdy = bus.o_ready;
      chk1("o_ready", bus.o_ready, exp_rdy);
      ovm = (mq.size() > 0) && (mq[0].stage == 2);
      @(posedge clk);
      if (ovm && rdy) begin
         m_cbr += {31'd0, mq[0].cbr};
         m_ctk += {31'd0, mq[0].r.taken};
         m_cmp += {31'd0, mq[0].r.redirect};
         void'(mq.pop_front());
      end
      if (fl) begin
         mq.delete();
      end else begin
         if (mq.size() > 0 && mq[0].stage == 1) mq[0].stage = 2;
         if (v && exp_rdy) begin
            e.stage = 1;
            e.r     = ref_res(x);
            e.cbr   = x.br && !e.r.illegal;
            mq.push_back(e);
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic do_reset(input logic fl);
      rst = 1'b1;
      drive(rand_in(), 1'b1, 1'b1, fl);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(idle, 1'b0, 1'b1, 1'b0);
      mq.delete();
      m_cbr = '0; m_ctk = '0; m_cmp = '0;
      #1;
      chk1 ("rst_o_valid",     bus.o_valid,       1'b0);
      chk1 ("rst_o_ready",     bus.o_ready,       1'b1);
      chk1 ("rst_o_taken",     bus.o_taken,       1'b0);
      chk32("rst_o_target",    bus.o_target,      32'd0);
      chk32("rst_o_link",      bus.o_link,        32'd0);
      chk1 ("rst_o_redirect",  bus.o_redirect,    1'b0);
      chk32("rst_cnt_branch",  bus.o_cnt_branch,  32'd0);
      chk32("rst_cnt_taken",   bus.o_cnt_taken,   32'd0);
      chk32("rst_cnt_mispred", bus.o_cnt_mispred, 32'd0);
   endtask

   vec_t tbl[13];

   initial begin
      logic [31:0] t_cbr, t_ctk, t_cmp;
      logic [5:0]  pat;
      in_t         a;
      rst = 1'b1;
      drive(idle, 1'b0, 1'b1, 1'b0);
      drive_s(1'b0, 32'd0);
      m_cbr = '0; m_ctk = '0; m_cmp = '0;
      repeat (2) @(posedge clk);
      #1;
      do_reset(1'b0);

      //                 br   jal  jalr f3    pred pred_tgt       pc             op1            op2            imm
      tbl[0].x  = mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0,         32'h100,       32'd5,         32'd5,         32'h20);
      tbl[0].e  = mr(1'b1, 32'h120,  32'h104, 1'b1, 1'b0, 1'b0);
      tbl[1].x  = mk(1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 32'h0,         32'h200,       32'hFFFF_FFFA, 32'd0,         32'h40);
      tbl[1].e  = mr(1'b1, 32'h240,  32'h204, 1'b1, 1'b0, 1'b0);
      tbl[2].x  = mk(1'b1, 1'b0, 1'b0, 3'd6, 1'b0, 32'h0,         32'h200,       32'hFFFF_FFFA, 32'd0,         32'h40);
      tbl[2].e  = mr(1'b0, 32'h204,  32'h204, 1'b0, 1'b0, 1'b0);
      tbl[3].x  = mk(1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 32'h310,       32'h300,       32'h8000_0000, 32'd1,         32'h10);
      tbl[3].e  = mr(1'b0, 32'h304,  32'h304, 1'b1, 1'b0, 1'b0);
      tbl[4].x  = mk(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 32'h0,         32'h400,       32'h1003,      32'd0,         32'h0);
      tbl[4].e  = mr(1'b1, 32'h1002, 32'h404, 1'b0, 1'b0, 1'b1);
      tbl[5].x  = mk(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 32'h1000,      32'h404,       32'h1001,      32'd0,         32'h0);
      tbl[5].e  = mr(1'b1, 32'h1000, 32'h408, 1'b0, 1'b0, 1'b0);
      tbl[6].x  = mk(1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 32'h508,       32'h500,       32'd1,         32'd1,         32'h8);
      tbl[6].e  = mr(1'b0, 32'h504,  32'h504, 1'b0, 1'b1, 1'b0);
      tbl[7].x  = mk(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 32'h10,        32'hFFFF_FFF0, 32'd0,         32'd0,         32'h20);
      tbl[7].e  = mr(1'b1, 32'h10,   32'hFFFF_FFF4, 1'b0, 1'b0, 1'b0);
      tbl[8].x  = mk(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 32'h5F0,       32'h600,       32'd3,         32'd4,         32'hFFFF_FFF0);
      tbl[8].e  = mr(1'b1, 32'h5F0,  32'h604, 1'b0, 1'b0, 1'b0);
      tbl[9].x  = mk(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 32'h5F4,       32'h600,       32'd3,         32'd4,         32'hFFFF_FFF0);
      tbl[9].e  = mr(1'b1, 32'h5F0,  32'h604, 1'b1, 1'b0, 1'b0);
      tbl[10].x = mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 32'h0,         32'h700,       32'd0,         32'd0,         32'h8);
      tbl[10].e = mr(1'b0, 32'h704,  32'h704, 1'b0, 1'b0, 1'b0);
      tbl[11].x = mk(1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 32'h0,         32'h800,       32'd0,         32'hFFFF_FFFF, 32'h4);
      tbl[11].e = mr(1'b0, 32'h804,  32'h804, 1'b0, 1'b0, 1'b0);
      tbl[12].x = mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0,         32'h900,       32'd0,         32'd0,         32'h6);
      tbl[12].e = mr(1'b1, 32'h906,  32'h904, 1'b0, 1'b0, 1'b1);

      t_cbr = '0; t_ctk = '0; t_cmp = '0;
      for (int i = 0; i < 13; i++) begin
         cycle(tbl[i].x, 1'b1, 1'b1, 1'b0);
         cycle(idle, 1'b0, 1'b1, 1'b0);
         chk1 ($sformatf("vec%0d_valid", i),    bus.o_valid,      1'b1);
         chk1 ($sformatf("vec%0d_taken", i),    bus.o_taken,      tbl[i].e.taken);
         chk32($sformatf("vec%0d_target", i),   bus.o_target,     tbl[i].e.target);
         chk32($sformatf("vec%0d_link", i),     bus.o_link,       tbl[i].e.link);
         chk1 ($sformatf("vec%0d_redirect", i), bus.o_redirect,   tbl[i].e.redirect);
         chk1 ($sformatf("vec%0d_illegal", i),  bus.o_illegal,    tbl[i].e.illegal);
         chk1 ($sformatf("vec%0d_misalign", i), bus.o_misaligned, tbl[i].e.mis);
         t_cbr += {31'd0, tbl[i].x.br && !tbl[i].e.illegal};
         t_ctk += {31'd0, tbl[i].e.taken};
         t_cmp += {31'd0, tbl[i].e.redirect};
         cycle(idle, 1'b0, 1'b1, 1'b0);
         chk32($sformatf("vec%0d_cnt_branch", i),  bus.o_cnt_branch,  t_cbr);
         chk32($sformatf("vec%0d_cnt_taken", i),   bus.o_cnt_taken,   t_ctk);
         chk32($sformatf("vec%0d_cnt_mispred", i), bus.o_cnt_mispred, t_cmp);
      end

      // Back-to-back: four entries produce four consecutive results.
      pat = '0;
      for (int i = 0; i < 6; i++) begin
         cycle((i < 4) ? rand_in() : idle, (i < 4), 1'b1, 1'b0);
         pat[i] = bus.o_valid;
      end
      chk32("b2b_valid_pattern", {26'd0, pat}, 32'h0000_001E);

      // Stall: S1 and S2 fill, o_ready drops, output holds.
      a = rand_in();
      cycle(a, 1'b1, 1'b0, 1'b0);
      cycle(rand_in(), 1'b1, 1'b0, 1'b0);
      chk32("stall_target_first", bus.o_target, ref_res(a).target);
      cycle(rand_in(), 1'b1, 1'b0, 1'b0);
      chk1 ("stall_o_ready", last_rdy, 1'b0);
      chk1 ("stall_valid", bus.o_valid, 1'b1);
      chk32("stall_target_hold", bus.o_target, ref_res(a).target);
      cycle(idle, 1'b0, 1'b0, 1'b0);
      chk32("stall_target_hold2", bus.o_target, ref_res(a).target);
      for (int i = 0; i < 3; i++) cycle(idle, 1'b0, 1'b1, 1'b0);

      // Flush with both stages full: pipeline empties, counters stay.
      cycle(rand_in(), 1'b1, 1'b0, 1'b0);
      cycle(rand_in(), 1'b1, 1'b0, 1'b0);
      chk1("flush_pre_valid", bus.o_valid, 1'b1);
      t_ctk = m_ctk;
      cycle(rand_in(), 1'b1, 1'b0, 1'b1);
      chk1 ("flush_o_valid", bus.o_valid, 1'b0);
      chk32("flush_cnt_taken_kept", bus.o_cnt_taken, t_ctk);
      cycle(idle, 1'b0, 1'b1, 1'b0);
      chk1("flush_still_empty", bus.o_valid, 1'b0);

      // Reset mid-stream, with flush asserted in the same cycle.
      cycle(rand_in(), 1'b1, 1'b1, 1'b0);
      cycle(rand_in(), 1'b1, 1'b1, 1'b0);
      do_reset(1'b1);

      // Counter wrap on a narrow instance: eight taken jumps bring a 3-bit counter back to 0.
      for (int i = 0; i < 12; i++) begin
         drive_s((i < 8), 32'h1000 + 32'(i * 4));
         @(posedge clk);
         #1;
         if (i == 8)  chk32("wrap_cnt_taken_7", {29'd0, bus_s.o_cnt_taken}, 32'd7);
         if (i == 11) begin
            chk32("wrap_cnt_taken_0",  {29'd0, bus_s.o_cnt_taken},  32'd0);
            chk32("wrap_cnt_branch_0", {29'd0, bus_s.o_cnt_branch}, 32'd0);
         end
      end
      drive_s(1'b0, 32'd0);

      // Randomized traffic with stalls, flushes and occasional resets.
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 199) == 0)
            do_reset($urandom_range(0, 1) != 0);
         else
            cycle(rand_in(), $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 39) == 0);
      end
      for (int i = 0; i < 3; i++) cycle(idle, 1'b0, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Pipelined branch/jump resolution stage directly downstream of the operand comparator.
- Consumes two 32-bit operands plus decoded control fields.
- Evaluates the RV32I branch condition (BEQ/BNE/BLT/BGE/BLTU/BGEU), computes the target and link address, and detects mispredictions against the fetch-stage prediction.
- Produces a registered redirect to fetch and keeps wrap-around performance counters.

Parameters:
- XLEN, 32, operand/PC width.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- i_flush  input  1  kill all in-flight entries (higher priority than advance, lower than rst).
- i_valid  input  1  upstream entry valid.
- o_ready  output  1  this block can accept an entry this cycle.
- i_is_branch  input  1  conditional branch.
- i_is_jal  input  1  JAL.
- i_is_jalr  input  1  JALR.
- i_funct3  input  3  branch condition code.
- i_pred_taken  input  1  fetch predicted taken.
- i_pred_target  input  XLEN  fetch predicted target.
- i_pc  input  XLEN  instruction PC.
- i_op_1  input  XLEN  rs1 value.
- i_op_2  input  XLEN  rs2 value.
- i_imm  input  XLEN  sign-extended immediate.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_taken  output  1  resolved taken.
- o_target  output  XLEN  resolved next PC (target if taken, else pc+4).
- o_link  output  XLEN  pc+4 for rd write.
- o_redirect  output  1  misprediction, fetch must restart at o_target.
- o_illegal  output  1  i_is_branch with funct3 = 010 or 011.
- o_misaligned  output  1  taken target with bit1 = 1.
- o_cnt_branch  output  CNT_W  retired conditional branches.
- o_cnt_taken  output  CNT_W  retired taken branches/jumps.
- o_cnt_mispred  output  CNT_W  retired redirects.

Behaviour:
- Two stages: S1 (compare + adder), S2 (output register). Each stage has a valid bit and a payload.
- Accept/advance rules:
  - Entry accepted when i_valid && o_ready.
  - Result consumed when o_valid && i_ready.
  - Latency: accepted in cycle N, appears on outputs in cycle N+2 if no stall.
  - S2 loads from S1 when S2 is empty or being consumed.
  - S1 loads from input when S1 is empty or moving to S2.
  - o_ready = !s1_valid || s2 can load. It is combinational from i_ready; no skid buffer.
  - Full throughput: 1 entry/cycle while i_ready = 1.
  - While stalled, outputs and payloads hold stable.
- Compare, computed in S1 as d = {1'b0,op_1} + {1'b0,~op_2} + 1:
  - eq = (op_1 == op_2).
  - ltu = !d[32].
  - lt = d[31] ^ ovf, where ovf = (op_1[31] != op_2[31]) && (d[31] != op_1[31]).
- Condition by funct3:
  - 000 eq; 001 !eq; 100 lt; 101 !lt; 110 ltu; 111 !ltu.
  - 010/011: o_illegal = 1, o_taken = 0, o_redirect = 0.
- Target, all modulo 2^XLEN with wrap and no overflow flag:
  - Branch/JAL target = pc + imm.
  - JALR target = (op_1 + imm) & ~1.
  - o_link = pc + 4.
- Taken:
  - JAL/JALR always taken.
  - Branch taken per condition.
  - None of the three flags set → not taken, no redirect, counters untouched.
- Misalignment: if taken and target[1] = 1, o_misaligned = 1, o_taken = 1, o_redirect = 0.
- Redirect = !illegal && !misaligned && ((taken != pred_taken) || (taken && target != pred_target)).
- Counters:
  - Increment only when a result is consumed (o_valid && i_ready).
  - cnt_branch counts i_is_branch && !illegal.
  - cnt_taken counts taken (branch or jump).
  - cnt_mispred counts redirect.
  - Wrap from all-ones to 0.
- Reset: s1_valid = s2_valid = 0; all outputs 0, including o_target, o_link and counters. o_ready = 1 in the first cycle after reset.
- Flush:
  - Clears s1_valid and s2_valid next cycle.
  - An input accepted in the flush cycle is discarded.
  - A result consumed in the flush cycle still counts.
  - Counters are not cleared.
- Simultaneous rst and i_flush: rst wins.
- A redirect does not self-flush; the flush comes externally.

Test Plan:
- BEQ: op_1 = 5, op_2 = 5, pc = 0x100, imm = 0x20, pred not taken → cycle+2: o_taken = 1, o_target = 0x120, o_redirect = 1, o_link = 0x104, cnt_mispred = 1.
- BLT vs BLTU: op_1 = 0xFFFFFFFA, op_2 = 0:
  - BLT → taken.
  - BLTU → not taken, o_target = pc+4.
  - BGE with op_1 = 0x80000000, op_2 = 1 → not taken.
- JALR: op_1 = 0x1003, imm = 0 → o_target = 0x1002, o_misaligned = 1, o_redirect = 0. With op_1 = 0x1001 → target 0x1000, no misalign.
- Back-to-back: 4 entries with i_ready = 1 → 4 results on consecutive cycles. Holding i_ready = 0 for 3 cycles → o_ready drops after S1 and S2 fill, outputs stable, no entry lost or duplicated.
- i_flush with S1 and S2 full → o_valid = 0 next cycle, counters unchanged.
- rst asserted mid-stream → all outputs and counters 0.
- funct3 = 010 → o_illegal = 1, not counted in cnt_branch.
- Force cnt_taken to 0xFFFFFFFF → after the next taken result it reads 0.
